// File: rtl/solver_cmd_sequencer_pkg.sv
// Shared definitions for the Solver command sequencer.
//   Work codes, Solver data widths, the FSM state type and the
//   command record stored in the command FIFO.
package solver_seq_pkg;

  localparam int RAW_W = 60;
  localparam int ENC_W = 78;

  localparam logic [1:0] WORK_ENC = 2'd0;
  localparam logic [1:0] WORK_DEC = 2'd1;
  localparam logic [1:0] WORK_RAW = 2'd2;
  localparam logic [1:0] WORK_ILL = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [1:0]       work;
    logic [ENC_W-1:0] data;
  } cmd_t;

endpackage

// File: rtl/solver_cmd_sequencer_if.sv
// Bus bundle around the sequencer: command stream in, response
// stream out, and the Solver's work/data/result wires.
//   slave  : the sequencer's view (accepts commands, drives Solver)
//   master : the host/Solver side view
interface solver_cmd_sequencer_if;
  import solver_seq_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_work;
  logic [ENC_W-1:0] cmd_data;

  logic [1:0]       sol_work;
  logic [RAW_W-1:0] sol_data_raw;
  logic [ENC_W-1:0] sol_data_enc;
  logic [ENC_W-1:0] sol_out_enc;
  logic [RAW_W-1:0] sol_out_raw;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_work;
  logic [ENC_W-1:0] rsp_data;
  logic             rsp_err;

  modport slave (
    input  cmd_valid, cmd_work, cmd_data, rsp_ready, sol_out_enc, sol_out_raw,
    output cmd_ready, rsp_valid, rsp_work, rsp_data, rsp_err,
           sol_work, sol_data_raw, sol_data_enc
  );

  modport master (
    output cmd_valid, cmd_work, cmd_data, rsp_ready, sol_out_enc, sol_out_raw,
    input  cmd_ready, rsp_valid, rsp_work, rsp_data, rsp_err,
           sol_work, sol_data_raw, sol_data_enc
  );

endinterface

// File: rtl/solver_cmd_sequencer_fifo.sv
// Synchronous command FIFO holding {work, data} records.
//   Clk, Rst_n        : clock, async active-low reset (empties the FIFO)
//   i_push/i_push_data: write when not full
//   i_pop / o_head    : head entry is visible combinationally; pop advances
//   o_full / o_empty  : status, told apart by the extra pointer bit
module solver_cmd_fifo
  import solver_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic i_push,
  input  cmd_t i_push_data,
  input  logic i_pop,
  output cmd_t o_head,
  output logic o_full,
  output logic o_empty
);

  localparam int AW = $clog2(DEPTH);

  cmd_t        r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_push_ok;
  logic        w_pop_ok;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: entries are only read behind the write pointer.
  always_ff @(posedge Clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/solver_cmd_sequencer.sv
// Front-end for the Solver encrypt/decrypt core. Buffers commands,
// drives the Solver and holds its inputs for the operation latency,
// then returns the captured result on the response stream.
//   Clk, Rst_n : clock, async active-low reset
//   sif        : command / Solver / response bundle (slave view)
module solver_cmd_sequencer
  import solver_seq_pkg::*;
#(
  parameter int ENC_LAT    = 3,
  parameter int DEC_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input logic                   Clk,
  input logic                   Rst_n,
  solver_cmd_sequencer_if.slave sif
);

  localparam int MAX_LAT = (ENC_LAT > DEC_LAT) ? ENC_LAT : DEC_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  seq_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_sol_work;
  logic [RAW_W-1:0] r_sol_data_raw;
  logic [ENC_W-1:0] r_sol_data_enc;
  logic             r_rsp_valid;
  logic [1:0]       r_rsp_work;
  logic [ENC_W-1:0] r_rsp_data;
  logic             r_rsp_err;

  cmd_t w_push_data;
  cmd_t w_head;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_push_data = {sif.cmd_work, sif.cmd_data};
  assign w_push      = sif.cmd_valid && !w_full;
  // Pops only from IDLE, so leaving RESP always costs one cycle.
  assign w_pop       = (r_state == ST_IDLE) && !w_empty;

  solver_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_sol_work     <= '0;
      r_sol_data_raw <= '0;
      r_sol_data_enc <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_work     <= '0;
      r_rsp_data     <= '0;
      r_rsp_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            case (w_head.work)
              WORK_ENC: begin
                r_sol_work     <= WORK_ENC;
                r_sol_data_raw <= w_head.data[RAW_W-1:0];
                r_cnt          <= CNT_W'(ENC_LAT);
                r_state        <= ST_RUN;
              end
              WORK_DEC: begin
                r_sol_work     <= WORK_DEC;
                r_sol_data_enc <= w_head.data;
                r_cnt          <= CNT_W'(DEC_LAT);
                r_state        <= ST_RUN;
              end
              WORK_RAW: begin
                r_sol_work <= WORK_RAW;
                r_cnt      <= CNT_W'(DEC_LAT);
                r_state    <= ST_RUN;
              end
              default: begin
                // Illegal work: answer directly, Solver stays untouched.
                r_rsp_valid <= 1'b1;
                r_rsp_work  <= WORK_ILL;
                r_rsp_data  <= '0;
                r_rsp_err   <= 1'b1;
                r_state     <= ST_RESP;
              end
            endcase
          end
        end
        ST_RUN: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_rsp_valid <= 1'b1;
            r_rsp_work  <= r_sol_work;
            r_rsp_err   <= 1'b0;
            if (r_sol_work == WORK_ENC) r_rsp_data <= sif.sol_out_enc;
            else r_rsp_data <= {{(ENC_W-RAW_W){1'b0}}, sif.sol_out_raw};
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (sif.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sif.cmd_ready    = !w_full;
  assign sif.sol_work     = r_sol_work;
  assign sif.sol_data_raw = r_sol_data_raw;
  assign sif.sol_data_enc = r_sol_data_enc;
  assign sif.rsp_valid    = r_rsp_valid;
  assign sif.rsp_work     = r_rsp_work;
  assign sif.rsp_data     = r_rsp_data;
  assign sif.rsp_err      = r_rsp_err;

endmodule

// File: doc/solver_cmd_sequencer.md
Name: solver_cmd_sequencer

Overview:
Upstream front-end for the Solver encrypt/decrypt core.
- Accepts work commands over a valid/ready stream and buffers them in a small FIFO.
- Drives the Solver's work/data inputs and holds them stable for the operation's fixed latency.
- Captures the Solver result and returns it on a valid/ready response stream. This replaces the open-loop fixed-delay sequencing currently used around the Solver.

Parameters:
ENC_LAT, 3, Clk cycles the Solver inputs are held before the work-0 (encrypt) result is sampled
DEC_LAT, 2, Clk cycles held before the work-1/work-2 result is sampled
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)

Ports:
Clk  in  1  clock, rising edge
Rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_work  in  2  0=encrypt, 1=decrypt, 2=re-read raw output, 3=illegal
cmd_data  in  78  payload; work 0 uses [59:0], work 1 uses [77:0], work 2/3 ignore it
sol_work  out  2  to Solver work_2
sol_data_raw  out  60  to Solver data_1_80
sol_data_enc  out  78  to Solver data_2_96
sol_out_enc  in  78  from Solver output_1_96
sol_out_raw  in  60  from Solver output_2_80
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_work  out  2  work code of the response
rsp_data  out  78  work 0: sol_out_enc; work 1/2: {18'b0, sol_out_raw}; work 3: 0
rsp_err  out  1  high for a work-3 response

Behaviour:
- Reset (async assert, sync deassert by the system):
  - FIFO empty; FSM IDLE; cmd_ready=1.
  - rsp_valid=0, rsp_work=0, rsp_data=0, rsp_err=0.
  - sol_work=0, sol_data_raw=0, sol_data_enc=0.
  - Any in-flight command is discarded, with no response.
- FIFO:
  - cmd_ready = !full.
  - Push and pop in the same cycle are allowed, and occupancy is unchanged.
  - Pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished by an extra pointer bit.
- FSM states:
  - IDLE:
    - If the FIFO is non-empty, pop the head.
    - Work 0: register sol_work=0 and sol_data_raw=data[59:0], load cnt=ENC_LAT, go to RUN.
    - Work 1: register sol_work=1 and sol_data_enc=data, load cnt=DEC_LAT, go to RUN.
    - Work 2: register sol_work=2 (data regs unchanged), load cnt=DEC_LAT, go to RUN.
    - Work 3: load rsp_err=1, rsp_data=0, rsp_work=3, assert rsp_valid, go to RESP. The Solver is not touched.
  - RUN:
    - cnt decrements each cycle.
    - On the edge where cnt==1, capture the selected Solver output into rsp_data, set rsp_work and rsp_err=0, assert rsp_valid, go to RESP.
    - sol_* stay constant for the whole of RUN.
  - RESP:
    - Hold rsp_* stable while rsp_valid && !rsp_ready.
    - On handshake: deassert rsp_valid and go to IDLE.
    - IDLE may pop the next command in that same edge only if the pop is registered from IDLE. That is, return-to-IDLE costs one cycle.
- Latency, empty FIFO, rsp_ready held high:
  - Command accepted at edge E.
  - Popped and sol_* updated at E+1.
  - rsp_valid rises at E+1+LAT: 4 cycles for encrypt, 3 for decrypt/re-read, 1 for illegal.
  - Throughput: one command per LAT+2 cycles.
- sol_* outputs retain their last value between commands; they are never cleared except by reset.
- Only one command is in flight; the Solver is never re-driven while in RUN or RESP.
- Backpressure on rsp_ready never drops data. The FIFO keeps accepting until full.

Decomposition:
- Package solver_seq_pkg:
  - Work-code constants: WORK_ENC=0, WORK_DEC=1, WORK_RAW=2.
  - Widths: RAW_W=60, ENC_W=78.
  - FSM state encoding: IDLE, RUN, RESP.
- One sub-module: solver_cmd_fifo, a synchronous FIFO with FIFO_DEPTH entries of {work[1:0], data[77:0]}. It uses Clk, async Rst_n and push/pop/full/empty.

Test Plan:
- Reset then single encrypt: cmd_work=0, cmd_data[59:0]=60'h0_0000_0000_00AB → sol_work=0 and sol_data_raw=..AB one cycle after accept; rsp_valid 4 cycles after accept; rsp_data equals the Solver model's enc(..AB); rsp_err=0.
- Decrypt round-trip: feed the previous rsp_data as work 1 → rsp_valid 3 cycles after accept; rsp_data[59:0]=60'h..AB; rsp_data[77:60]=0.
- Backpressure/full: rsp_ready=0, push 6 encrypt commands → cmd_ready drops after 4 FIFO entries plus 1 in flight; the first rsp is held stable; releasing rsp_ready yields all 5 accepted responses in order, each with the correct data.
- Illegal work 3 with cmd_data=all-ones → rsp_valid after 1 cycle, rsp_err=1, rsp_data=0, rsp_work=3; sol_* unchanged.
- Async reset mid-RUN: assert Rst_n=0 two cycles into an encrypt → rsp_valid=0 and FIFO empty immediately (no clock needed); after release, a new decrypt completes normally with 3-cycle latency.
- Work 2 after decrypt → sol_work=2 held for 2 cycles; rsp_data[59:0] equals the Solver's output_2_80.
